// File: rtl/data_memory_pkg.sv
// Shared definitions for the data_memory block.
//   dm_state_e    : controller states (CLEAR, IDLE, LOAD)
//   DATA_W_DEF    : default data word width
//   ADDR_W_DEF    : default address width
package data_memory_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } dm_state_e;

endpackage

// File: rtl/dm_ram.sv
// Single-write-port RAM with a registered read port.
//   clk    : clock, all updates on rising edge
//   reset  : synchronous active-high, clears only the read register
//   we     : write enable, waddr/wdata : write address/data
//   re     : read request, raddr : read address
//   rdata  : registered read data, holds while no read is issued
//   rvalid : rdata carries the result of a read issued the cycle before
module dm_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // The array has no reset: contents are only zeroed by the controller's walk.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking read of mem gives the pre-write value on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/data_memory.sv
// Data memory with a zero-fill walk after reset, a burst loader port and a
// CPU store/fetch port.
//   clk, reset                        : clock, synchronous active-high reset
//   load_start/load_base              : start a burst at load_base (IDLE only)
//   load_valid/is_instruction/
//   cpu_input/load_last               : loader beats; instruction beats are not stored
//   wr_en/wr_addr/wr_data             : CPU store port (ignored during CLEAR)
//   rd_en/rd_addr                     : CPU read request, 1-cycle latency
//   data/data_valid                   : registered read result and its qualifier
//   busy                              : high in CLEAR or LOAD
//   load_count                        : data beats stored in current/last burst
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | writing 0 to mem[ptr], ptr walks 0..DEPTH-1
// ST_IDLE  | CPU access only, waiting for load_start
// ST_LOAD  | storing loader data beats at ptr until a load_last beat
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic              is_instruction,
  input  logic [DATA_W-1:0] cpu_input,
  input  logic              load_last,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              busy,
  output logic [ADDR_W:0]   load_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   COUNT_MAX   = (ADDR_W + 1)'(DEPTH);
  localparam dm_state_e         RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  dm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_STATE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write arbitration for the single RAM port: clear walk > loader beat > CPU store.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;

    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = ptr_q;
        ram_wdata = '0;
        ptr_d     = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        ram_we = wr_en;
        if (load_start) begin
          ptr_d   = load_base;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        ram_we = wr_en;
        if (load_valid) begin
          if (!is_instruction) begin
            ram_we    = 1'b1;
            ram_waddr = ptr_q;
            ram_wdata = cpu_input;
            ptr_d     = ptr_q + ADDR_W'(1);
            if (cnt_q != COUNT_MAX) begin
              cnt_d = cnt_q + (ADDR_W + 1)'(1);
            end
          end
          if (load_last) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase

    // An aborted load or clear must not leave a stray write behind.
    if (reset) begin
      ram_we = 1'b0;
    end
  end

  dm_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (data),
    .rvalid(data_valid)
  );

  assign busy       = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
  assign load_count = cnt_q;

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter CLEAR_ON_RESET, default 1; 1 = zero-fill the memory after reset, 0 = skip the fill.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 load_start  in  1  pulse; begins a burst load at load_base.
REQ-007 load_base  in  ADDR_W  burst start address, sampled with load_start.
REQ-008 load_valid  in  1  loader beat valid.
REQ-009 is_instruction  in  1  beat qualifier; 1 = instruction beat, not stored here.
REQ-010 cpu_input  in  DATA_W  loader beat data.
REQ-011 load_last  in  1  marks the final beat of a burst.
REQ-012 wr_en / wr_addr / wr_data  in  1 / ADDR_W / DATA_W  CPU store port.
REQ-013 rd_en / rd_addr  in  1 / ADDR_W  CPU operand fetch request.
REQ-014 data  out  DATA_W  registered operand data.
REQ-015 data_valid  out  1  data holds the result of a read issued on the previous cycle.
REQ-016 busy  out  1  high during CLEAR or LOAD.
REQ-017 load_count  out  ADDR_W+1  data beats stored in the current or last burst.

Function
REQ-018 FSM states: CLEAR, IDLE, LOAD.
REQ-019 CLEAR: write 0 to address ptr; ptr increments by 1 each cycle; go to IDLE after the write to DEPTH-1 (DEPTH cycles).
REQ-020 CLEAR_ON_RESET=0: leave reset directly to IDLE; memory contents undefined.
REQ-021 IDLE + load_start: ptr <= load_base, load_count <= 0, go to LOAD; load_start in other states ignored.
REQ-022 LOAD, beat (load_valid=1, is_instruction=0): memory[ptr] <= cpu_input, ptr <= ptr+1 modulo DEPTH (wraps DEPTH-1 -> 0), load_count +1 saturating at DEPTH.
REQ-023 LOAD, beat with is_instruction=1: no write, ptr unchanged, load_count unchanged.
REQ-024 LOAD, any beat with load_last=1 (data or instruction): go to IDLE after that beat.
REQ-025 CPU write: memory[wr_addr] <= wr_data when wr_en=1 in IDLE or LOAD; ignored in CLEAR.
REQ-026 Same-cycle loader data write and CPU write to the same address: loader value is stored.
REQ-027 Read: rd_en=1 in cycle N -> data = memory[rd_addr] and data_valid=1 in cycle N+1 (1-cycle latency); data_valid=0 in cycle N+1 when rd_en=0 in cycle N.
REQ-028 data holds its value while data_valid=0.
REQ-029 Read-during-write to the same address returns the old (pre-write) value.
REQ-030 Reads are accepted in every state; a read during CLEAR returns current contents (0 or not-yet-cleared).
REQ-031 busy = 1 exactly when state is CLEAR or LOAD.

Reset
REQ-032 reset=1: state <= CLEAR when CLEAR_ON_RESET=1, else IDLE; ptr <= 0; load_count <= 0; data <= 0; data_valid <= 0.
REQ-033 reset asserted mid-LOAD or mid-CLEAR: abort the operation, reenter the reset state, then restart the full clear (CLEAR_ON_RESET=1).
REQ-034 reset does not clear memory contents directly; zeroing is done only by the CLEAR walk.

Structure
REQ-035 Shared package holds the FSM state enum (CLEAR, IDLE, LOAD) and the DATA_W/ADDR_W defaults.
REQ-036 One sub-module, dm_ram: a single-write-port, registered-read RAM array; FSM, ptr and write arbitration stay in data_memory.

Verification
REQ-037 Reset, then idle: busy=1 for exactly 16 cycles, then 0; read of every address returns 0x00.
REQ-038 load_start with base 0xE, data beats 0x11,0x22,0x33 (last on 0x33): addresses 0xE,0xF,0x0 = 0x11,0x22,0x33 (wrap), load_count=3.
REQ-039 Burst with an instruction beat between data beats 0xAA,0xBB at base 2: addr2=0xAA, addr3=0xBB, load_count=2.
REQ-040 Same cycle: loader writes 0x55 and CPU writes 0x99 to address 5 -> later read of 5 returns 0x55.
REQ-041 addr7 holds 0x01; write 0x7F and read addr7 in the same cycle -> data=0x01 next cycle; a read the cycle after returns 0x7F.
REQ-042 reset asserted at cycle 5 of a burst -> busy stays 1 for 16 further cycles; all reads return 0x00; load_count=0.
